// File: rtl/instr_fetch_buffer.sv
// Fetch front-end: credit-limited ITCM requests, in-order responses
// buffered with their PCs, redirect flush with wrong-path discard.
module instr_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_jump,
  input  logic [31:0] pc_jump_addr,
  output logic        itcm_req_valid,
  input  logic        itcm_req_ready,
  output logic [31:0] itcm_addr,
  input  logic        itcm_rsp_valid,
  input  logic [31:0] itcm_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_U = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // PCs are held as word addresses; the low two bits are always zero
  logic [29:0]      r_fetch_w;
  logic [29:0]      r_rsp_w;
  logic [31:0]      r_instr [DEPTH];
  logic [29:0]      r_pcw   [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] r_discard;

  logic [29:0]      w_req_w;
  logic [CNT_W:0]   w_used;
  logic             w_accept;
  logic             w_drop;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_acc_c;
  logic [CNT_W-1:0] w_rsp_c;
  logic             w_unused;

  assign w_unused = ^pc_jump_addr[1:0];

  assign w_used  = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_req_w = pc_jump ? pc_jump_addr[31:2] : r_fetch_w;

  assign itcm_req_valid = rst_n & (w_used < DEPTH_U);
  assign itcm_addr      = {2'b00, w_req_w};

  assign w_accept = itcm_req_valid & itcm_req_ready;
  assign w_drop   = itcm_rsp_valid & (pc_jump | (r_discard != '0));
  assign w_push   = itcm_rsp_valid & ~w_drop;

  assign id_valid = (r_count != '0) & ~pc_jump;
  assign w_pop    = id_valid & id_ready;
  assign id_instr = r_instr[r_rptr];
  assign id_pc    = {r_pcw[r_rptr], 2'b00};

  assign w_acc_c = CNT_W'(w_accept);
  assign w_rsp_c = CNT_W'(itcm_rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_w  <= RESET_PC[31:2];
      r_rsp_w    <= RESET_PC[31:2];
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      r_inflight <= r_inflight + w_acc_c - w_rsp_c;
      if (pc_jump) begin
        // a request accepted now already fetched the target
        r_fetch_w <= pc_jump_addr[31:2] + 30'(w_accept);
        r_rsp_w   <= pc_jump_addr[31:2];
        r_discard <= r_inflight - w_rsp_c;
      end else begin
        if (w_accept)
          r_fetch_w <= r_fetch_w + 30'd1;
        if (w_push)
          r_rsp_w <= r_rsp_w + 30'd1;
        if (w_drop)
          r_discard <= r_discard - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pcw[i]   <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      a_no_overflow:
        assert (!(w_push && !w_pop && r_count == DEPTH_C));
      if (pc_jump) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_instr[r_wptr] <= itcm_rsp_data;
          r_pcw[r_wptr]   <= r_rsp_w;
          r_wptr          <= r_wptr + 1'b1;
        end
        if (w_pop)
          r_rptr <= r_rptr + 1'b1;
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

endmodule
